csr_trap_unit: RTL

//  Machine-mode CSR file and trap/return sequencer, executing the commands produced by the

---
 rtl/csr_trap_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_unit.sv
// ============================================================================
// Module  : csr_trap_unit
// Machine-mode CSR file, 64-bit cycle/instret counters and trap/MRET sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MHARTID     = 32'h0000_0000,
    parameter logic [31:0] MISA        = 32'h4000_0100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [2:0]  i_sysop,
    input  logic [1:0]  i_csr_access,
    input  logic        i_illegal,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_pc,
    input  logic        i_retire,
    output logic [31:0] o_rdata,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_csr_illegal
);

    localparam logic [2:0] c_SYSOP_NOP  = 3'd0;
    localparam logic [2:0] c_SYSOP_RW   = 3'd1;
    localparam logic [2:0] c_SYSOP_RS   = 3'd2;
    localparam logic [2:0] c_SYSOP_RC   = 3'd3;
    localparam logic [2:0] c_SYSOP_EC   = 3'd4;
    localparam logic [2:0] c_SYSOP_EB   = 3'd5;
    localparam logic [2:0] c_SYSOP_MRET = 3'd6;

    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MISA      = 12'h301;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;
    localparam logic [11:0] c_MTVAL     = 12'h343;
    localparam logic [11:0] c_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_CYCLE     = 12'hC00;
    localparam logic [11:0] c_INSTRET   = 12'hC02;
    localparam logic [11:0] c_CYCLEH    = 12'hC80;
    localparam logic [11:0] c_INSTRETH  = 12'hC82;
    localparam logic [11:0] c_MHARTID   = 12'hF14;

    localparam logic [31:0] c_CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] c_CAUSE_BREAK   = 32'd3;
    localparam logic [31:0] c_CAUSE_ECALL   = 32'd11;

    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [11:0] w_addr;
    logic [31:0] w_src;
    logic [31:0] w_old;
    logic        w_impl;
    logic [31:0] w_new;
    logic        w_csr_ill;
    logic        w_ill;
    logic        w_ecall;
    logic        w_ebreak;
    logic        w_trap;
    logic        w_mret;
    logic        w_wen;
    logic [31:0] w_cause;
    logic [31:0] w_tval;

    assign w_addr = i_inst[31:20];
    assign w_src  = i_inst[14] ? {27'd0, i_inst[19:15]} : i_rs1_data;

    always_comb begin
        w_old  = 32'd0;
        w_impl = 1'b1;
        case (w_addr)
            c_MSTATUS:               w_old = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
            c_MISA:                  w_old = MISA;
            c_MTVEC:                 w_old = r_mtvec;
            c_MSCRATCH:              w_old = r_mscratch;
            c_MEPC:                  w_old = r_mepc;
            c_MCAUSE:                w_old = r_mcause;
            c_MTVAL:                 w_old = r_mtval;
            c_MCYCLE,   c_CYCLE:     w_old = r_mcycle[31:0];
            c_MCYCLEH,  c_CYCLEH:    w_old = r_mcycle[63:32];
            c_MINSTRET, c_INSTRET:   w_old = r_minstret[31:0];
            c_MINSTRETH, c_INSTRETH: w_old = r_minstret[63:32];
            c_MHARTID:               w_old = MHARTID;
            default:                 w_impl = 1'b0;
        endcase
    end

    always_comb begin
        case (i_sysop)
            c_SYSOP_RS: w_new = w_old | w_src;
            c_SYSOP_RC: w_new = w_old & ~w_src;
            default:    w_new = w_src;
        endcase
    end

    // Addresses with [11:10]==2'b11 are the read-only CSR space.
    assign w_csr_ill = i_valid && (i_csr_access != 2'b00) &&
                       (!w_impl || (i_csr_access[0] && (w_addr[11:10] == 2'b11)));
    assign w_ill     = i_valid && (i_illegal || w_csr_ill);
    assign w_ecall   = i_valid && (i_sysop == c_SYSOP_EC);
    assign w_ebreak  = i_valid && (i_sysop == c_SYSOP_EB);
    assign w_trap    = w_ill || w_ecall || w_ebreak;
    assign w_mret    = i_valid && (i_sysop == c_SYSOP_MRET) && !w_trap;
    assign w_wen     = i_valid && i_csr_access[0] && !w_trap;

    always_comb begin
        if (w_ill) begin
            w_cause = c_CAUSE_ILLEGAL;
            w_tval  = i_inst;
        end else if (w_ecall) begin
            w_cause = c_CAUSE_ECALL;
            w_tval  = 32'd0;
        end else begin
            w_cause = c_CAUSE_BREAK;
            w_tval  = i_pc;
        end
    end

    assign o_rdata       = (i_valid && i_csr_access[1]) ? w_old : 32'd0;
    assign o_redirect    = w_trap || w_mret;
    assign o_redirect_pc = w_trap ? r_mtvec : (w_mret ? r_mepc : 32'd0);
    assign o_csr_illegal = w_csr_ill;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= {MTVEC_RESET[31:2], 2'b00};
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_trap) begin
                r_mepc   <= {i_pc[31:2], 2'b00};
                r_mcause <= w_cause;
                r_mtval  <= w_tval;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (w_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wen) begin
                case (w_addr)
                    c_MSTATUS: begin
                        r_mie  <= w_new[3];
                        r_mpie <= w_new[7];
                    end
                    c_MTVEC:    r_mtvec    <= {w_new[31:2], 2'b00};
                    c_MSCRATCH: r_mscratch <= w_new;
                    c_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
                    c_MCAUSE:   r_mcause   <= w_new;
                    c_MTVAL:    r_mtval    <= w_new;
                    default: ;
                endcase
            end

            // A software write to either half replaces that cycle's increment entirely.
            if (w_wen && (w_addr == c_MCYCLE)) begin
                r_mcycle[31:0] <= w_new;
            end else if (w_wen && (w_addr == c_MCYCLEH)) begin
                r_mcycle[63:32] <= w_new;
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_wen && (w_addr == c_MINSTRET)) begin
                r_minstret[31:0] <= w_new;
            end else if (w_wen && (w_addr == c_MINSTRETH)) begin
                r_minstret[63:32] <= w_new;
            end else if (i_retire && !w_trap) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end

endmodule

`default_nettype wire
